// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RISC24 prefetching fetch stage.
// Entries pair the fetch address with its instruction word.
package rv_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DROP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO with flush; head is read straight from storage (0-cycle read, 1-cycle write-to-head).
// No internal overflow/underflow guard: the caller only pushes with room and only pops when non-empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching fetch stage: one outstanding req/ack fetch into a FIFO of {pc, instr}; head valid 1 cycle after ack.
// Stops requesting when the FIFO plus the in-flight fetch would overflow; redirect flushes and drops any in-flight data.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;

  fetch_entry_t      push_entry, head_entry;
  logic [CW-1:0]     occ, occ_next;
  logic              fifo_full, fifo_empty;
  logic              ack, pop, push, pending_after;

  // An ack with no live request (e.g. one abandoned by reset) is ignored.
  assign ack           = mem_ack & mem_req_q;
  assign pop           = ~fifo_empty & instr_ready;
  assign push          = ack & (state_q == S_RUN) & ~redirect & (~fifo_full | pop);
  assign pending_after = mem_req_q & ~ack;
  assign occ_next      = occ + CW'(push) - CW'(pop);
  assign push_entry    = '{pc: mem_addr_q, instr: mem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_RUN: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (pending_after) state_d = S_DROP;
          else               mem_req_d = 1'b0;
        end else begin
          if (ack) fetch_pc_d = mem_addr_q + ADDR_W'(1);
          if (!pending_after) begin
            mem_req_d  = (occ_next < DEPTH_C);
            mem_addr_d = fetch_pc_d;
          end
        end
      end
      S_DROP: begin
        if (redirect) fetch_pc_d = redirect_pc;
        // FIFO was flushed on entry, so there is always room for the restart fetch.
        if (ack) begin
          state_d    = S_RUN;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_d;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = ~fifo_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random ready/redirect/latency traffic,
// checked against a program-order model of requested and delivered addresses.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, mem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [15:0] instr, instr_pc, redirect_pc;

  logic        mem_req_w, mem_ack_w, instr_valid_w;
  logic [15:0] mem_addr_w, mem_rdata_w, instr_w, instr_pc_w;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h2F1B) ^ 16'hC35A;
  endfunction

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // Second instance starts near the top of the address space with zero-wait memory and a core that never stalls.
  assign mem_ack_w   = mem_req_w;
  assign mem_rdata_w = mem_word(mem_addr_w);

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .reset(reset),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
    .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(16'h0000)
  );

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: next address to be delivered / requested, in program order.
  logic [15:0] exp_pc, exp_req, exp_w, prev_addr;
  bit          prev_pend, dropping, flush_pend, rand_lat;
  int          cnt, lat, stall;
  logic        obs_valid, obs_req;
  logic [15:0] obs_pc;

  task automatic model_reset();
    exp_pc = 16'h0000; exp_req = 16'h0000; exp_w = 16'hFFFE;
    prev_pend = 0; dropping = 0; flush_pend = 0; cnt = 0; stall = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    obs_valid = instr_valid; obs_pc = instr_pc; obs_req = mem_req;
    if (prev_pend) begin
      check_eq("req_hold", mem_req, 1);
      check_eq("addr_hold", mem_addr, prev_addr);
    end else if (mem_req) begin
      check_eq("req_addr", mem_addr, exp_req);
    end
    if (flush_pend) check_eq("flush_valid", instr_valid, 0);
    flush_pend = 0;
    if (instr_valid_w) begin
      check_eq("wrap_pc", instr_pc_w, exp_w);
      check_eq("wrap_instr", instr_w, mem_word(exp_w));
      exp_w++;
    end
  endtask

  task automatic mem_drive();
    if (!mem_req) begin
      cnt = 0; mem_ack = 1'b0; mem_rdata = 16'($urandom);
    end else if (cnt >= lat) begin
      cnt = 0; mem_ack = 1'b1; mem_rdata = mem_word(mem_addr);
      if (rand_lat) lat = $urandom_range(0, 3);
    end else begin
      cnt++; mem_ack = 1'b0; mem_rdata = 16'($urandom);
    end
  endtask

  task automatic commit();
    if (instr_valid && instr_ready) begin
      check_eq("pc", instr_pc, exp_pc);
      check_eq("instr", instr, mem_word(exp_pc));
      exp_pc++;
      stall = 0;
    end else begin
      stall++;
    end
    if (mem_ack) begin
      if (dropping) dropping = 0;
      else          exp_req = mem_addr + 16'd1;
    end
    if (redirect) begin
      if (mem_req && !mem_ack) dropping = 1;
      exp_pc = redirect_pc; exp_req = redirect_pc; flush_pend = 1;
    end
    prev_pend = mem_req && !mem_ack;
    prev_addr = mem_addr;
  endtask

  task automatic cycle(input logic rdy);
    tick();
    mem_drive();
    instr_ready = rdy;
    redirect = 1'b0;
    commit();
  endtask

  task automatic apply_reset();
    reset = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_addr", mem_addr, 16'h0000);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 16'h0000);
    check_eq("rst_ipc", instr_pc, 16'h0000);
    check_eq("rst_addr_w", mem_addr_w, 16'hFFFE);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] pc);
    int n = 0;
    do begin cycle(1'b1); n++; end while (!obs_valid && n < 20);
    check_eq({tag, "_valid"}, obs_valid, 1);
    check_eq({tag, "_pc"}, obs_pc, pc);
  endtask

  initial begin
    bit hit;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0; rand_lat = 0; lat = 0;
    model_reset();

    // Reset release, zero-wait memory: first valid 2 cycles later, then 0,1,2,3 back to back.
    apply_reset();
    cycle(1'b1);
    check_eq("t1_req", obs_req, 1);
    check_eq("t1_valid_early", obs_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      check_eq("t1_valid", obs_valid, 1);
      check_eq("t1_pc", obs_pc, 16'(i));
    end
    repeat (6) cycle(1'b1);

    // Backpressure: fetching stops with the FIFO full, then resumes without gap or duplicate.
    apply_reset();
    repeat (6) cycle(1'b0);
    check_eq("t2_req_idle", obs_req, 0);
    check_eq("t2_hold_pc", obs_pc, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      check_eq("t2_valid", obs_valid, 1);
      check_eq("t2_pc", obs_pc, 16'(i));
    end

    // 3-cycle memory, redirect one cycle after the request rises: in-flight data dropped.
    apply_reset();
    lat = 3;
    cycle(1'b1);
    check_eq("t3_req", obs_req, 1);
    tick(); mem_drive();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    commit();
    wait_valid("t3", 16'h0040);
    repeat (8) cycle(1'b1);

    // Redirect coinciding with the ack for address 5: address 5 never delivered.
    apply_reset();
    lat = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick(); mem_drive();
      instr_ready = 1'b1;
      hit = mem_ack && (mem_addr == 16'h0005);
      redirect = hit; redirect_pc = 16'h0010;
      commit();
    end
    check_eq("t4_hit", hit, 1);
    wait_valid("t4", 16'h0010);
    repeat (4) cycle(1'b1);

    // Reset while a 4-cycle request is pending; a stale ack around release must be ignored.
    apply_reset();
    lat = 4;
    for (int i = 0; i < 30 && !(obs_valid && obs_req); i++) cycle(1'b0);
    check_eq("t6_setup_valid", obs_valid, 1);
    check_eq("t6_setup_req", obs_req, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_req_drop", mem_req, 0);
    check_eq("t6_valid_drop", instr_valid, 0);
    mem_ack = 1'b1; mem_rdata = ~mem_word(16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    lat = 0;
    wait_valid("t6", 16'h0000);
    repeat (4) cycle(1'b1);

    // Random traffic: ready, redirects (some to the wrap point) and memory latency.
    apply_reset();
    rand_lat = 1; lat = 1;
    for (int i = 0; i < 3000; i++) begin
      tick(); mem_drive();
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      commit();
      if (stall > 80) begin
        check_eq("liveness_stall", stall, 0);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
